// File: rtl/rs_dec_31_29_ser_pkg.sv
// Shared definitions for the serial RS(31,29) decoder.
//   - code geometry (N, K, symbol width)
//   - GF(2^5) field: primitive polynomial x^5+x^2+1, alpha = 5'h02
//   - alpha constants used by the syndrome and solver datapaths
//   - FSM state encoding
//   - helper functions for constant-coefficient multiplier generation
package rs_dec_31_29_ser_pkg;

   localparam int N     = 31;
   localparam int K     = 29;
   localparam int SYM_W = 5;

   localparam logic [SYM_W:0]   PRIM_POLY = 6'b100101;
   localparam logic [SYM_W-1:0] ALPHA     = 5'h02;
   localparam logic [SYM_W-1:0] ALPHA2    = 5'h04;
   // alpha^30 == alpha^-1, steps the magnitude register backwards
   localparam logic [SYM_W-1:0] ALPHA30   = 5'h12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_SOLVE,
      ST_OUTPUT
   } state_t;

   function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                               input logic [SYM_W-1:0] b);
      logic [SYM_W-1:0] acc;
      logic [SYM_W-1:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < SYM_W; i++) begin
         if (b[i]) acc = acc ^ x;
         x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0])
                        : {x[SYM_W-2:0], 1'b0};
      end
      return acc;
   endfunction

   function automatic logic [SYM_W-1:0] gf_alpha_pow(input int e);
      logic [SYM_W-1:0] r;
      r = 5'h01;
      for (int i = 0; i < e; i++) r = gf_mul(r, ALPHA);
      return r;
   endfunction

endpackage

// File: rtl/rs_dec_31_29_ser_gf_mul_const_5.sv
// Constant multiplier in GF(2^5): y = a * alpha^EXP.
// Reduces to a small XOR network since the coefficient is a constant.
//   a : input symbol
//   y : product
module gf_mul_const_5
   import rs_dec_31_29_ser_pkg::*;
#(
   parameter int EXP = 1
) (
   input  logic [SYM_W-1:0] a,
   output logic [SYM_W-1:0] y
);

   localparam logic [SYM_W-1:0] COEF = (EXP == 1)  ? ALPHA  :
                                       (EXP == 2)  ? ALPHA2 :
                                       (EXP == 30) ? ALPHA30 :
                                                     gf_alpha_pow(EXP);

   assign y = gf_mul(a, COEF);

endmodule

// File: rtl/rs_dec_31_29_ser.sv
// Serial RS(31,29) decoder, t=1, over GF(2^5).
// Collects 31 symbols (first = highest degree), computes S1=r(alpha) and
// S2=r(alpha^2) by Horner, searches for the error location in a fixed
// 31-cycle solve phase, then streams the 29 data symbols with any single
// symbol error corrected.
//
// state   | meaning
// IDLE    | waiting for a symbol with sof_i
// COLLECT | buffering symbols, updating syndromes
// SOLVE   | 31-step search: t=S1*alpha^j vs S2, u=S1*alpha^-j
// OUTPUT  | streaming 29 data symbols
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   sym_i/sym_valid_i   received symbol stream, sof_i marks symbol 0
//   in_ready_o          high in IDLE/COLLECT (low while rst_i is high)
//   sym_o/sym_valid_o   corrected data symbols, sof_o on the first
//   corrected_o         single error fixed (valid with sof_o)
//   uncorrectable_o     error detected but not correctable (valid with sof_o)
module rs_dec_31_29_ser
   import rs_dec_31_29_ser_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [SYM_W-1:0] sym_i,
   input  logic             sym_valid_i,
   input  logic             sof_i,
   output logic             in_ready_o,
   output logic [SYM_W-1:0] sym_o,
   output logic             sym_valid_o,
   output logic             sof_o,
   output logic             corrected_o,
   output logic             uncorrectable_o
);

   localparam logic [4:0] LAST_IN  = 5'(N - 1);
   localparam logic [4:0] LAST_OUT = 5'(K - 1);

   state_t           state;
   logic [4:0]       cnt;
   logic [SYM_W-1:0] s1, s2, t, u, p, e;
   logic             found;
   logic [SYM_W-1:0] buf_q [N];

   logic [SYM_W-1:0] s1_a, s2_a2, t_a, u_a30;
   logic [SYM_W-1:0] s1_nxt, s2_nxt;
   logic             accept;
   logic             both_nz, one_zero, do_fix;
   logic [4:0]       fix_idx;

   gf_mul_const_5 #(.EXP(1))  u_mul_s1 (.a(s1), .y(s1_a));
   gf_mul_const_5 #(.EXP(2))  u_mul_s2 (.a(s2), .y(s2_a2));
   gf_mul_const_5 #(.EXP(1))  u_mul_t  (.a(t),  .y(t_a));
   gf_mul_const_5 #(.EXP(30)) u_mul_u  (.a(u),  .y(u_a30));

   assign in_ready_o = ~rst_i & ((state == ST_IDLE) | (state == ST_COLLECT));
   assign accept     = sym_valid_i & in_ready_o;
   assign s1_nxt     = s1_a ^ sym_i;
   assign s2_nxt     = s2_a2 ^ sym_i;

   assign both_nz  = (s1 != '0) & (s2 != '0);
   assign one_zero = (s1 == '0) ^ (s2 == '0);
   // degree p maps to buffer index 30-p; p<=1 lands in parity, not output
   assign fix_idx  = LAST_IN - p;
   assign do_fix   = both_nz & found & (p > 5'd1);

   // Buffer is not reset; a new word always overwrites it from index 0.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         if (sof_i)
            buf_q[0] <= sym_i;
         else if (state == ST_COLLECT)
            buf_q[cnt] <= sym_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         s1              <= '0;
         s2              <= '0;
         t               <= '0;
         u               <= '0;
         p               <= '0;
         e               <= '0;
         found           <= 1'b0;
         sym_o           <= '0;
         sym_valid_o     <= 1'b0;
         sof_o           <= 1'b0;
         corrected_o     <= 1'b0;
         uncorrectable_o <= 1'b0;
      end else begin
         sym_valid_o     <= 1'b0;
         sof_o           <= 1'b0;
         corrected_o     <= 1'b0;
         uncorrectable_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept && sof_i) begin
                  s1    <= sym_i;
                  s2    <= sym_i;
                  cnt   <= 5'd1;
                  state <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (accept) begin
                  if (sof_i) begin
                     s1  <= sym_i;
                     s2  <= sym_i;
                     cnt <= 5'd1;
                  end else begin
                     s1  <= s1_nxt;
                     s2  <= s2_nxt;
                     cnt <= cnt + 5'd1;
                     if (cnt == LAST_IN) begin
                        t     <= s1_nxt;
                        u     <= s1_nxt;
                        cnt   <= '0;
                        found <= 1'b0;
                        state <= ST_SOLVE;
                     end
                  end
               end
            end
            ST_SOLVE: begin
               t <= t_a;
               u <= u_a30;
               // t = S1*alpha^j equals S2 exactly when alpha^j = S2/S1
               if (!found && (t == s2)) begin
                  found <= 1'b1;
                  p     <= cnt;
                  e     <= u;
               end
               cnt <= cnt + 5'd1;
               if (cnt == LAST_IN) begin
                  cnt   <= '0;
                  state <= ST_OUTPUT;
               end
            end
            ST_OUTPUT: begin
               sym_valid_o <= 1'b1;
               sym_o       <= (do_fix && (fix_idx == cnt)) ? (buf_q[cnt] ^ e)
                                                            : buf_q[cnt];
               if (cnt == '0) begin
                  sof_o           <= 1'b1;
                  corrected_o     <= both_nz;
                  uncorrectable_o <= one_zero;
               end
               cnt <= cnt + 5'd1;
               if (cnt == LAST_OUT) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_dec_31_29_ser.sv
// Directed bench for rs_dec_31_29_ser. Words are the all-zero codeword or
// x^10*g(x) (g = x^2 + 6x + 8, i.e. symbols 18/19/20 = 1/6/8), with hand-placed
// symbol errors and hand-worked syndromes/expected flags.
module tb_rs_dec_31_29_ser;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [4:0] sym_i;
   logic       sym_valid_i;
   logic       sof_i;
   logic       in_ready_o;
   logic [4:0] sym_o;
   logic       sym_valid_o;
   logic       sof_o;
   logic       corrected_o;
   logic       uncorrectable_o;

   rs_dec_31_29_ser dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .sym_i           (sym_i),
      .sym_valid_i     (sym_valid_i),
      .sof_i           (sof_i),
      .in_ready_o      (in_ready_o),
      .sym_o           (sym_o),
      .sym_valid_o     (sym_valid_o),
      .sof_o           (sof_o),
      .corrected_o     (corrected_o),
      .uncorrectable_o (uncorrectable_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0] i1;
      logic [4:0] v1;
      logic [4:0] i2;
      logic [4:0] v2;
      logic       cw;
      logic       exp_corr;
      logic       exp_unc;
   } vec_t;

   vec_t       vecs [12];
   logic [4:0] txw  [31];
   logic [4:0] expw [29];
   logic       ex_corr, ex_unc;
   int         nvec = 0;
   int         nbad = 0;
   int         vcount = 0;

   always @(negedge clk_i) if (sym_valid_o === 1'b1) vcount++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic build(input vec_t v);
      for (int k = 0; k < 31; k++) txw[k] = 5'h00;
      if (v.cw) begin
         txw[18] = 5'h01;
         txw[19] = 5'h06;
         txw[20] = 5'h08;
      end
      for (int k = 0; k < 29; k++) expw[k] = txw[k];
      txw[v.i1] = txw[v.i1] ^ v.v1;
      txw[v.i2] = txw[v.i2] ^ v.v2;
      if (v.exp_unc)
         for (int k = 0; k < 29; k++) expw[k] = txw[k];
      ex_corr = v.exp_corr;
      ex_unc  = v.exp_unc;
   endtask

   task automatic run_word(input int abort_at, input bit restart_junk, input bit solve_junk);
      int v0;
      int lat;
      v0 = vcount;
      // non-sof symbol in IDLE is dropped
      @(negedge clk_i); sym_i = 5'h1F; sym_valid_i = 1'b1; sof_i = 1'b0;
      @(posedge clk_i);
      if (restart_junk)
         for (int k = 0; k < 10; k++) begin
            @(negedge clk_i); sym_i = 5'(k + 3); sof_i = (k == 0); sym_valid_i = 1'b1;
            @(posedge clk_i);
         end
      for (int k = 0; k < 31; k++) begin
         @(negedge clk_i); sym_i = txw[k]; sof_i = (k == 0); sym_valid_i = 1'b1;
         @(posedge clk_i);
      end
      @(negedge clk_i);
      if (solve_junk) begin
         sym_i = 5'h1F; sof_i = 1'b1; sym_valid_i = 1'b1;
      end else begin
         sym_valid_i = 1'b0; sof_i = 1'b0;
      end
      lat = 0;
      while (!sym_valid_o && lat < 100) begin
         @(posedge clk_i); lat++;
         @(negedge clk_i);
         if (lat == 10) chk("ready_in_solve", in_ready_o, 0);
         if (lat == 20) begin sym_valid_i = 1'b0; sof_i = 1'b0; end
      end
      chk("latency", lat, 32);
      for (int i = 0; i < 29; i++) begin
         if (i == abort_at) begin
            rst_i = 1'b1;
            #1;
            chk("abort_valid", sym_valid_o, 0);
            chk("abort_ready", in_ready_o, 0);
            @(negedge clk_i); rst_i = 1'b0;
            #1;
            chk("ready_after_rst", in_ready_o, 1);
            v0 = vcount;
            repeat (40) @(negedge clk_i);
            chk("no_output_after_abort", 32'(vcount - v0), 0);
            return;
         end
         chk("out_valid", sym_valid_o, 1);
         chk("out_sof", sof_o, (i == 0));
         chk("out_data", sym_o, expw[i]);
         chk("out_corrected", corrected_o, (i == 0) ? ex_corr : 1'b0);
         chk("out_uncorrectable", uncorrectable_o, (i == 0) ? ex_unc : 1'b0);
         @(posedge clk_i); @(negedge clk_i);
      end
      chk("valid_after_word", sym_valid_o, 0);
      chk("ready_after_word", in_ready_o, 1);
      @(posedge clk_i); @(negedge clk_i);
      chk("word_count", 32'(vcount - v0), 29);
   endtask

   initial begin
      rst_i = 1'b1; sym_i = '0; sym_valid_i = 1'b0; sof_i = 1'b0;
      //            i1     v1     i2     v2     cw    corr  unc
      vecs[0]  = '{5'd0,  5'h00, 5'd0,  5'h00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{5'd0,  5'h01, 5'd0,  5'h00, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{5'd12, 5'h1B, 5'd0,  5'h00, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{5'd30, 5'h07, 5'd0,  5'h00, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{5'd29, 5'h12, 5'd30, 5'h01, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{5'd0,  5'h00, 5'd0,  5'h00, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{5'd5,  5'h0A, 5'd0,  5'h00, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{5'd19, 5'h1F, 5'd0,  5'h00, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{5'd28, 5'h1F, 5'd0,  5'h00, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{5'd29, 5'h05, 5'd0,  5'h00, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{5'd28, 5'h04, 5'd27, 5'h01, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{5'd28, 5'h02, 5'd27, 5'h01, 1'b0, 1'b0, 1'b1};

      repeat (3) @(negedge clk_i);
      chk("rst_valid", sym_valid_o, 0);
      chk("rst_sof", sof_o, 0);
      chk("rst_corrected", corrected_o, 0);
      chk("rst_uncorrectable", uncorrectable_o, 0);
      chk("rst_ready_held", in_ready_o, 0);
      rst_i = 1'b0;
      #1;
      chk("rst_ready_released", in_ready_o, 1);

      for (int v = 0; v < 12; v++) begin
         build(vecs[v]);
         run_word(-1, 1'b0, (v == 1 || v == 6));
      end

      // sof reasserted at symbol 10: only the second word is decoded
      build(vecs[2]);
      run_word(-1, 1'b1, 1'b0);

      // reset during output cycle 5, then a clean word
      build(vecs[7]);
      run_word(5, 1'b0, 1'b0);
      build(vecs[6]);
      run_word(-1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
